// File: rtl/pmem_arbiter_rr.sv
// N-channel arbiter in front of a single physical-memory port.
// Round-robin or fixed priority, one transaction in flight, registered pmem controls.
module pmem_arbiter_rr #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256,
    parameter bit RR_EN  = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        ch_read,
    input  logic [NUM_CH-1:0]        ch_write,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
    input  logic [NUM_CH*LINE_W-1:0] ch_wdata,
    output logic [LINE_W-1:0]        ch_rdata,
    output logic [NUM_CH-1:0]        ch_resp,
    output logic                     pmem_read,
    output logic                     pmem_write,
    output logic [ADDR_W-1:0]        pmem_address,
    output logic [LINE_W-1:0]        pmem_wdata,
    input  logic [LINE_W-1:0]        pmem_rdata,
    input  logic                     pmem_resp,
    output logic                     busy
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        DONE
    } state_t;

    state_t              state;
    logic [CH_W-1:0]     owner;
    logic [CH_W-1:0]     rr_ptr;
    logic [CH_W-1:0]     win;
    logic [NUM_CH-1:0]   req;
    logic                any_req;
    logic [ADDR_W-1:0]   addr_a  [NUM_CH];
    logic [LINE_W-1:0]   wdata_a [NUM_CH];

    assign req     = ch_read | ch_write;
    assign any_req = |req;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            addr_a[i]  = ch_addr[i*ADDR_W +: ADDR_W];
            wdata_a[i] = ch_wdata[i*LINE_W +: LINE_W];
        end
    end

    // Scan from the highest offset down so the closest requester to the start wins.
    always_comb begin : pick_c
        int idx;
        idx = 0;
        win = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = k + (RR_EN ? int'(rr_ptr) : 0);
            if (idx >= NUM_CH)
                idx = idx - NUM_CH;
            if (req[idx])
                win = CH_W'(idx);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            owner        <= '0;
            rr_ptr       <= '0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
            ch_rdata     <= '0;
            ch_resp      <= '0;
            busy         <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        owner        <= win;
                        pmem_address <= addr_a[win];
                        pmem_wdata   <= wdata_a[win];
                        pmem_write   <= ch_write[win];
                        pmem_read    <= ch_read[win] & ~ch_write[win];
                        busy         <= 1'b1;
                        state        <= GRANT;
                    end
                end
                GRANT: begin
                    if (pmem_resp) begin
                        if (pmem_read)
                            ch_rdata <= pmem_rdata;
                        pmem_read  <= 1'b0;
                        pmem_write <= 1'b0;
                        ch_resp    <= NUM_CH'(1) << owner;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    ch_resp <= '0;
                    busy    <= 1'b0;
                    if (RR_EN)
                        rr_ptr <= (owner == CH_W'(NUM_CH - 1)) ? '0 : owner + CH_W'(1);
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pmem_arbiter_rr.sv
// Bench for pmem_arbiter_rr: a round-robin and a fixed-priority instance,
// directed cases then random traffic against a transaction-level model.
module tb_pmem_arbiter_rr;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int LW = 256;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N-1:0]    ch_read      [2];
    logic [N-1:0]    ch_write     [2];
    logic [N*AW-1:0] ch_addr      [2];
    logic [N*LW-1:0] ch_wdata     [2];
    logic [LW-1:0]   ch_rdata     [2];
    logic [N-1:0]    ch_resp      [2];
    logic            pmem_read    [2];
    logic            pmem_write   [2];
    logic [AW-1:0]   pmem_address [2];
    logic [LW-1:0]   pmem_wdata   [2];
    logic [LW-1:0]   pmem_rdata   [2];
    logic            pmem_resp    [2];
    logic            busy         [2];

    int checks = 0;
    int errors = 0;
    int mptr [2];
    logic [LW-1:0] mrdata [2];

    pmem_arbiter_rr #(.NUM_CH(N), .ADDR_W(AW), .LINE_W(LW), .RR_EN(1'b1)) u_rr (
        .clk(clk), .rst(rst),
        .ch_read(ch_read[0]), .ch_write(ch_write[0]),
        .ch_addr(ch_addr[0]), .ch_wdata(ch_wdata[0]),
        .ch_rdata(ch_rdata[0]), .ch_resp(ch_resp[0]),
        .pmem_read(pmem_read[0]), .pmem_write(pmem_write[0]),
        .pmem_address(pmem_address[0]), .pmem_wdata(pmem_wdata[0]),
        .pmem_rdata(pmem_rdata[0]), .pmem_resp(pmem_resp[0]),
        .busy(busy[0])
    );

    pmem_arbiter_rr #(.NUM_CH(N), .ADDR_W(AW), .LINE_W(LW), .RR_EN(1'b0)) u_fp (
        .clk(clk), .rst(rst),
        .ch_read(ch_read[1]), .ch_write(ch_write[1]),
        .ch_addr(ch_addr[1]), .ch_wdata(ch_wdata[1]),
        .ch_rdata(ch_rdata[1]), .ch_resp(ch_resp[1]),
        .pmem_read(pmem_read[1]), .pmem_write(pmem_write[1]),
        .pmem_address(pmem_address[1]), .pmem_wdata(pmem_wdata[1]),
        .pmem_rdata(pmem_rdata[1]), .pmem_resp(pmem_resp[1]),
        .busy(busy[1])
    );

    function automatic int pick(input logic [N-1:0] req, input int ptr);
        for (int k = 0; k < N; k++)
            if (req[(ptr + k) % N])
                return (ptr + k) % N;
        return -1;
    endfunction

    function automatic logic [LW-1:0] rnd_line();
        logic [LW-1:0] v;
        for (int i = 0; i < LW / 32; i++)
            v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int d, input int c, input bit rd, input bit wr,
                           input logic [AW-1:0] a, input logic [LW-1:0] wd);
        ch_read[d][c]         = rd;
        ch_write[d][c]        = wr;
        ch_addr[d][c*AW +: AW]  = a;
        ch_wdata[d][c*LW +: LW] = wd;
    endtask

    task automatic idle_chk(input int d);
        chk("idle_strobes", {pmem_write[d], pmem_read[d]}, 2'b00);
        chk("idle_busy", busy[d], 1'b0);
        chk("idle_resp", ch_resp[d], '0);
        chk("idle_rdata", ch_rdata[d], mrdata[d]);
    endtask

    // One arbitration slot: either a full transaction or an idle cycle with a stray pmem_resp.
    task automatic txn(input int d, input int lat, input bit keep, input logic [LW-1:0] rd);
        logic [N-1:0]  req;
        int            w;
        bit            wr;
        logic [AW-1:0] a;
        logic [LW-1:0] wd;
        req = ch_read[d] | ch_write[d];
        w = pick(req, mptr[d]);
        if (w < 0) begin
            pmem_rdata[d] = rnd_line();
            pmem_resp[d]  = 1'b1;
            @(posedge clk); #1;
            pmem_resp[d]  = 1'b0;
            idle_chk(d);
            return;
        end
        wr = ch_write[d][w];
        a  = ch_addr[d][w*AW +: AW];
        wd = ch_wdata[d][w*LW +: LW];
        pmem_resp[d]  = 1'($urandom_range(0, 1));
        pmem_rdata[d] = rnd_line();
        @(posedge clk); #1;
        pmem_resp[d] = 1'b0;
        chk("grant_strobes", {pmem_write[d], pmem_read[d]}, {wr, !wr});
        chk("grant_addr", pmem_address[d], a);
        chk("grant_wdata", pmem_wdata[d], wd);
        chk("grant_busy", busy[d], 1'b1);
        chk("grant_resp", ch_resp[d], '0);
        for (int i = 0; i < lat; i++) begin
            ch_addr[d][w*AW +: AW]  = $urandom;
            ch_wdata[d][w*LW +: LW] = rnd_line();
            @(posedge clk); #1;
            chk("hold_addr", pmem_address[d], a);
            chk("hold_strobes", {pmem_write[d], pmem_read[d]}, {wr, !wr});
            chk("hold_resp", ch_resp[d], '0);
        end
        pmem_rdata[d] = rd;
        pmem_resp[d]  = 1'b1;
        @(posedge clk); #1;
        pmem_resp[d]  = 1'($urandom_range(0, 1));
        pmem_rdata[d] = rnd_line();
        if (!wr)
            mrdata[d] = rd;
        chk("done_resp", ch_resp[d], N'(1) << w);
        chk("done_strobes", {pmem_write[d], pmem_read[d]}, 2'b00);
        chk("done_rdata", ch_rdata[d], mrdata[d]);
        chk("done_busy", busy[d], 1'b1);
        if (!keep) begin
            ch_read[d][w]  = 1'b0;
            ch_write[d][w] = 1'b0;
        end
        @(posedge clk); #1;
        pmem_resp[d] = 1'b0;
        idle_chk(d);
        if (d == 0)
            mptr[d] = (w + 1) % N;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            ch_read[d]    = '0;
            ch_write[d]   = '0;
            ch_addr[d]    = '0;
            ch_wdata[d]   = '0;
            pmem_rdata[d] = '0;
            pmem_resp[d]  = 1'b0;
            mptr[d]       = 0;
            mrdata[d]     = '0;
        end
        #1 rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            idle_chk(d);
            chk("rst_addr", pmem_address[d], '0);
            chk("rst_wdata", pmem_wdata[d], '0);
        end
        @(posedge clk); #1;
        rst = 1'b0;

        // single read on channel 1
        set_req(0, 1, 1'b1, 1'b0, 32'h0000_1A40, '0);
        txn(0, 4, 1'b0, {8{32'hDEAD_BEEF}});
        // write on channel 0, read buffer must keep the line
        set_req(0, 0, 1'b0, 1'b1, 32'h0000_0080, {32{8'hA5}});
        txn(0, 2, 1'b0, rnd_line());
        // read+write on the same channel issues a write
        set_req(0, 3, 1'b1, 1'b1, 32'h0000_3000, rnd_line());
        txn(0, 1, 1'b0, rnd_line());

        // all four requesting continuously: 0,1,2,3,0
        for (int c = 0; c < N; c++)
            set_req(0, c, 1'b1, 1'b0, $urandom, rnd_line());
        for (int t = 0; t < 5; t++)
            txn(0, $urandom_range(0, 3), 1'b1, rnd_line());

        // reset in the middle of a read grant
        @(posedge clk); #1;
        chk("pre_rst_read", pmem_read[0], 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("rst_read", pmem_read[0], 1'b0);
        chk("rst_busy", busy[0], 1'b0);
        chk("rst_resp", ch_resp[0], '0);
        chk("rst_rdata", ch_rdata[0], '0);
        @(posedge clk); #1;
        rst = 1'b0;
        mptr[0]   = 0;
        mptr[1]   = 0;
        mrdata[0] = '0;
        mrdata[1] = '0;
        txn(0, 2, 1'b0, rnd_line());
        ch_read[0]  = '0;
        ch_write[0] = '0;

        // fixed priority: ch0 and ch2 both requesting
        set_req(1, 0, 1'b1, 1'b0, 32'h0000_0400, rnd_line());
        set_req(1, 2, 1'b0, 1'b1, 32'h0000_0800, rnd_line());
        for (int t = 0; t < 3; t++)
            txn(1, 1, 1'b1, rnd_line());
        txn(1, 1, 1'b0, rnd_line());
        txn(1, 1, 1'b0, rnd_line());

        // stray pmem_resp with nothing pending
        txn(0, 0, 1'b0, rnd_line());
        txn(1, 0, 1'b0, rnd_line());

        for (int d = 0; d < 2; d++) begin
            for (int it = 0; it < 80; it++) begin
                for (int c = 0; c < N; c++) begin
                    if (!(ch_read[d][c] | ch_write[d][c]) && $urandom_range(0, 2) == 0) begin
                        int op;
                        op = $urandom_range(0, 2);
                        set_req(d, c, op != 1, op != 0, $urandom, rnd_line());
                    end
                end
                txn(d, $urandom_range(0, 4), $urandom_range(0, 3) == 0, rnd_line());
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pmem_arbiter_rr.md
Name: pmem_arbiter_rr

Overview:
- Parametrised N-channel arbiter between cache-side requesters (I-cache, D-cache, prefetcher, ...) and a single physical-memory port.
- Replaces the 2-channel select-driven steering block with its own request FSM.
- Grants one channel per transaction, round-robin or fixed priority. Latches the granted address/data and drives registered pmem controls until pmem_resp. Returns the line through a registered read buffer with a one-cycle per-channel response pulse.

Parameters:
- NUM_CH, 2, number of requesting channels (2..8); channel 0 = I-cache by convention.
- ADDR_W, 32, address width.
- LINE_W, 256, cache-line width.
- RR_EN, 1, 1 = round-robin, 0 = fixed priority (lowest index wins).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- ch_read  in  NUM_CH  per-channel line-read request, level, held until that channel's ch_resp.
- ch_write  in  NUM_CH  per-channel line-write request, level, held until ch_resp.
- ch_addr  in  NUM_CH*ADDR_W  packed per-channel addresses; channel i at [i*ADDR_W +: ADDR_W].
- ch_wdata  in  NUM_CH*LINE_W  packed per-channel write lines.
- ch_rdata  out  LINE_W  shared registered read buffer, broadcast to all channels.
- ch_resp  out  NUM_CH  one-hot one-cycle completion pulse.
- pmem_read  out  1  registered memory read strobe.
- pmem_write  out  1  registered memory write strobe.
- pmem_address  out  ADDR_W  latched address of the granted request.
- pmem_wdata  out  LINE_W  latched write line.
- pmem_rdata  in  LINE_W  memory read data, valid with pmem_resp.
- pmem_resp  in  1  memory completion, one cycle.
- busy  out  1  high in GRANT and DONE.

Behaviour:
- Reset (async, any state): state=IDLE; pmem_read, pmem_write, ch_resp, busy = 0; pmem_address, pmem_wdata, ch_rdata = 0; owner=0; rr_ptr=0.
- Request of channel i: req[i] = ch_read[i] | ch_write[i].
- States: IDLE, GRANT, DONE.
- IDLE
  - If any req: pick winner w. RR_EN=1: first requesting index at or after rr_ptr, wrapping modulo NUM_CH. RR_EN=0: lowest requesting index.
  - Next edge: owner<=w; pmem_address<=ch_addr[w]; pmem_wdata<=ch_wdata[w].
  - Same edge: pmem_write<=ch_write[w]; pmem_read<=ch_read[w] & ~ch_write[w]. Write wins if a channel asserts both.
  - Go to GRANT. Latency: request at edge t -> pmem strobe high from edge t+1.
  - No request: stay IDLE.
- GRANT
  - Hold all pmem outputs constant; ignore changes on ch_* inputs.
  - On pmem_resp: ch_rdata<=pmem_rdata (captured on reads only; writes leave ch_rdata unchanged); pmem_read, pmem_write <= 0; ch_resp[owner]<=1.
  - Go to DONE. The response pulse is visible the cycle after pmem_resp.
- DONE (exactly one cycle)
  - ch_resp[owner]=1, all other ch_resp bits = 0.
  - Next edge: ch_resp<=0; rr_ptr<=(owner+1) mod NUM_CH (RR_EN=1 only); go IDLE.
  - The owner drops its request on the edge ending DONE. Arbitration resumes from IDLE, so a back-to-back transaction has a 1-cycle IDLE gap.
- pmem_resp in IDLE or DONE is ignored: no output change, no state change.
- ch_rdata holds its value until the next read completion.
- Only one of pmem_read/pmem_write may be high at any time; ch_resp is always zero or one-hot.
- rr_ptr wrap: owner=NUM_CH-1 -> rr_ptr=0.
- Starvation bound (RR_EN=1): a continuously requesting channel is granted within NUM_CH-1 intervening transactions.
- Reset asserted in GRANT: strobes drop immediately (async), the transaction is abandoned, no ch_resp is issued.

Test Plan:
- Reset: rst=1 mid-GRANT with pmem_read=1 -> pmem_read=0 same cycle; ch_resp=0, busy=0; after release, first grant goes to channel 0.
- Single read: ch_read[1]=1, ch_addr ch1=0x0000_1A40; pmem_resp 5 cycles later with rdata=0xDEAD...BEEF -> pmem_read high from the next edge with pmem_address=0x0000_1A40; ch_resp=2'b10 for exactly 1 cycle; ch_rdata=0xDEAD...BEEF.
- Write: ch_write[0]=1, addr=0x0000_0080, wdata=all-0xA5 -> pmem_write=1, pmem_wdata=all-0xA5, pmem_read=0; ch_resp=2'b01 after resp; ch_rdata unchanged.
- Round-robin: NUM_CH=4, all channels requesting continuously -> grant order 0,1,2,3,0; rr_ptr wraps from 3 to 0.
- Fixed priority: RR_EN=0, ch0 and ch2 requesting continuously -> ch0 granted every transaction; ch2 granted only after ch0 deasserts.
- Stray/conflict: pmem_resp pulsed in IDLE -> no ch_resp; ch_read[1]=ch_write[1]=1 -> write issued; ch_addr changed during GRANT -> pmem_address unchanged.
